rf_multiport: RTL and testbench

RF_MULTIPORT -- requirements
Module: rf_multiport

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_clear_fsm.sv | 58 +++++
 rtl/rf_multiport.sv | 65 ++++++
 tb/tb_rf_multiport.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and clear-FSM state type for the multiport register file.
package rf_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int NUM_WR_DEF = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_clear_fsm.sv
// Clear sequencer: sweeps addresses 1..DEPTH-1 to zero after reset or clr_req,
// then holds rf_ready high until the next accepted clear request.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          rf_ready
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

  rf_state_t     state;
  logic [AW-1:0] clr_ptr;

  // Address 0 is hardwired to zero, so the sweep starts at 1 and parks at DEPTH-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_ptr  <= FIRST_ADDR;
      rf_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST_ADDR) begin
            state    <= READY;
            rf_ready <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        READY: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_ptr  <= FIRST_ADDR;
            rf_ready <= 1'b0;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_ptr  <= FIRST_ADDR;
          rf_ready <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: NUM_RD combinational reads, NUM_WR prioritized writes,
// x0 hardwired to zero, self-clearing sweep. Define RF_BYPASS_EN for write-to-read forwarding.
module rf_multiport
  import rf_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NUM_RD = NUM_RD_DEF,
  parameter  int NUM_WR = NUM_WR_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]      reg_s,
  output logic [NUM_RD-1:0][XLEN-1:0]    reg_d,
  input  logic [NUM_WR-1:0][AW-1:0]      rd,
  input  logic [NUM_WR-1:0]              write_e,
  input  logic [NUM_WR-1:0][XLEN-1:0]    write_d,
  input  logic                           clr_req,
  output logic                           rf_ready
);

  logic [XLEN-1:0]   mem [DEPTH];
  logic              clr_we;
  logic [AW-1:0]     clr_addr;
  logic [NUM_WR-1:0] wr_acc;

  rf_clear_fsm #(.DEPTH(DEPTH)) u_clear (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .rf_ready (rf_ready)
  );

  // A write landing in the same cycle as an accepted clear is dropped.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++)
      wr_acc[j] = write_e[j] & rf_ready & ~clr_req & rst_n & (rd[j] != '0);
  end

  // Later ports overwrite earlier ones, so the highest index wins a collision.
  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_acc[j])
        mem[rd[j]] <= write_d[j];
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      reg_d[i] = mem[reg_s[i]];
`ifdef RF_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++)
        if (wr_acc[j] && (rd[j] == reg_s[i]))
          reg_d[i] = write_d[j];
`endif
      if (!rf_ready || (reg_s[i] == '0))
        reg_d[i] = '0;
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: directed vector table, clear/reset
// sequences and randomized traffic against a behavioural register-file model.
module tb_rf_multiport;
  import rf_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int AW    = $clog2(DEPTH);
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NR-1:0][AW-1:0]     reg_s = '0;
  logic [NR-1:0][XLEN-1:0]   reg_d;
  logic [NW-1:0][AW-1:0]     rd = '0;
  logic [NW-1:0]             write_e = '0;
  logic [NW-1:0][XLEN-1:0]   write_d = '0;
  logic                      clr_req = 1'b0;
  logic                      rf_ready;

  always #5 clk = ~clk;

  rf_multiport #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst_n(rst_n), .reg_s(reg_s), .reg_d(reg_d), .rd(rd),
    .write_e(write_e), .write_d(write_d), .clr_req(clr_req), .rf_ready(rf_ready)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: contents, ready flag and remaining clear cycles.
  logic [XLEN-1:0] m_mem [DEPTH];
  bit              m_ready = 1'b0;
  int              m_left  = 0;

  typedef struct {
    string           name;
    logic [AW-1:0]   rs0, rs1, wa0, wa1;
    logic [1:0]      we;
    logic [XLEN-1:0] wd0, wd1, e0, e1;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_acc(input int j);
    return rst_n && m_ready && !clr_req && write_e[j] && (rd[j] != '0);
  endfunction

  function automatic logic [XLEN-1:0] m_read(input int a);
    logic [XLEN-1:0] v;
    if (!m_ready || a == 0) return '0;
    v = m_mem[a];
    if (BYP)
      for (int j = 0; j < NW; j++)
        if (m_acc(j) && int'(rd[j]) == a) v = write_d[j];
    return v;
  endfunction

  task automatic m_edge();
    if (!rst_n) begin
      m_ready = 1'b0;
      m_left  = DEPTH - 1;
      foreach (m_mem[k]) m_mem[k] = '0;
    end else if (m_ready) begin
      if (clr_req) begin
        m_ready = 1'b0;
        m_left  = DEPTH - 1;
        foreach (m_mem[k]) m_mem[k] = '0;
      end else begin
        for (int j = 0; j < NW; j++)
          if (m_acc(j)) m_mem[rd[j]] = write_d[j];
      end
    end else begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; clr_req = 1'b0; write_e = '0;
  endtask

  // Counts cycles with rf_ready low (bounded); reads must stay zero throughout.
  task automatic count_clear(input string name, input bit poke, output int n);
    bit bad = 1'b0;
    n = 0;
    while (!rf_ready && n < 100) begin
      reg_s[0] = AW'($urandom_range(0, DEPTH - 1));
      reg_s[1] = AW'(4);
      if (poke) begin
        write_e = 2'b11; rd[0] = AW'(7); rd[1] = AW'(4);
        write_d[0] = $urandom; write_d[1] = $urandom;
        clr_req = (n == 10);
      end
      #1;
      if (reg_d[0] !== '0 || reg_d[1] !== '0) bad = 1'b1;
      n++;
      step();
    end
    idle();
    chk({name, "_reads_zero"}, 32'(bad), 32'd0);
    chk({name, "_cycles"}, n, DEPTH - 1);
  endtask

  initial begin
    int n;
    vecs[0]  = '{"wr_x4",      2, 4, 4, 0, 2'b01, 42, 0, 0, BYP ? 42 : 0};
    vecs[1]  = '{"wr_x2",      2, 4, 0, 2, 2'b10, 0, 99, BYP ? 99 : 0, 42};
    vecs[2]  = '{"rd_2_4",     2, 4, 0, 0, 2'b00, 0, 0, 99, 42};
    vecs[3]  = '{"wr_x0",      0, 4, 0, 0, 2'b01, 32'hDEADBEEF, 0, 0, 42};
    vecs[4]  = '{"rd_x0",      0, 2, 0, 0, 2'b00, 0, 0, 0, 99};
    vecs[5]  = '{"collide_x9", 9, 4, 9, 9, 2'b11, 5, 7, BYP ? 7 : 0, 42};
    vecs[6]  = '{"rd_x9",      9, 0, 0, 0, 2'b00, 0, 0, 7, 0};
    vecs[7]  = '{"rw_x4",      4, 9, 4, 0, 2'b01, 123, 0, BYP ? 123 : 42, 7};
    vecs[8]  = '{"rd_x4",      4, 2, 0, 0, 2'b00, 0, 0, 123, 99};
    vecs[9]  = '{"wr_10_11",  10, 11, 10, 11, 2'b11, 1, 2, BYP ? 1 : 0, BYP ? 2 : 0};
    vecs[10] = '{"rd_10_11",  10, 11, 0, 0, 2'b00, 0, 0, 1, 2};

    // Reset held for two edges, then the post-reset sweep.
    @(negedge clk);
    rst_n = 1'b0;
    step(); step();
    chk("reset_ready_low", 32'(rf_ready), 32'd0);
    rst_n = 1'b1;
    count_clear("reset", 1'b0, n);
    chk("reset_ready_high", 32'(rf_ready), 32'd1);

    foreach (vecs[v]) begin
      reg_s[0] = vecs[v].rs0; reg_s[1] = vecs[v].rs1;
      rd[0] = vecs[v].wa0; rd[1] = vecs[v].wa1;
      write_d[0] = vecs[v].wd0; write_d[1] = vecs[v].wd1;
      write_e = vecs[v].we;
      #1;
      chk({vecs[v].name, "_p0"}, reg_d[0], vecs[v].e0);
      chk({vecs[v].name, "_p1"}, reg_d[1], vecs[v].e1);
      chk({vecs[v].name, "_rdy"}, 32'(rf_ready), 32'd1);
      step();
    end
    idle();

    // Clear request with a simultaneous write to x5 that must be dropped.
    clr_req = 1'b1; write_e = 2'b01; rd[0] = AW'(5); write_d[0] = 77;
    reg_s[0] = AW'(4); reg_s[1] = AW'(5);
    #1;
    chk("clr_cycle_x4", reg_d[0], 123);
    chk("clr_cycle_x5", reg_d[1], 0);
    step();
    idle();
    chk("clr_ready_drop", 32'(rf_ready), 32'd0);
    count_clear("clear", 1'b1, n);
    reg_s[0] = AW'(4); reg_s[1] = AW'(5); #1;
    chk("post_clr_x4", reg_d[0], 0);
    chk("post_clr_x5", reg_d[1], 0);
    reg_s[0] = AW'(7); reg_s[1] = AW'(9); #1;
    chk("post_clr_x7", reg_d[0], 0);
    chk("post_clr_x9", reg_d[1], 0);
    step();

    // Reset in the middle of a sweep restarts it from address 1.
    clr_req = 1'b1; step(); idle();
    repeat (5) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    count_clear("midreset", 1'b0, n);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      clr_req = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NR; i++) reg_s[i] = AW'($urandom_range(0, 11));
      for (int j = 0; j < NW; j++) begin
        rd[j] = AW'($urandom_range(0, 11));
        write_d[j] = $urandom;
      end
      write_e = NW'($urandom);
      #1;
      if (rst_n) begin
        chk("rand_p0", reg_d[0], m_read(int'(reg_s[0])));
        chk("rand_p1", reg_d[1], m_read(int'(reg_s[1])));
        chk("rand_rdy", 32'(rf_ready), 32'(m_ready));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
